// File: rtl/simon_pkg.sv
// rtl/simon_pkg.sv - shared state encoding and segment constants for the score display
package simon_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_PLAY  = 2'd1,
      S_FLASH = 2'd2,
      S_OVER  = 2'd3
   } disp_state_e;

   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   // Active-low segments, bit 0 = segment a; anything outside 0..9 is dark.
   function automatic logic [6:0] digit_segments(input logic [5:0] digit);
      case (digit)
         6'd0:    return 7'b1000000;
         6'd1:    return 7'b1111001;
         6'd2:    return 7'b0100100;
         6'd3:    return 7'b0110000;
         6'd4:    return 7'b0011001;
         6'd5:    return 7'b0010010;
         6'd6:    return 7'b0000010;
         6'd7:    return 7'b1111000;
         6'd8:    return 7'b0000000;
         6'd9:    return 7'b0010000;
         default: return SEG_BLANK;
      endcase
   endfunction

endpackage

// File: rtl/score_display_ctrl_seven_seg.sv
// rtl/score_display_ctrl_seven_seg.sv - two-digit decimal 7-segment decoder for a 0..63 value
module score_display_ctrl_seven_seg
   import simon_pkg::*;
(
   input  logic [5:0] result_data,
   output logic [6:0] high_digit_display,
   output logic [6:0] low_digit_display
);

   logic [5:0] tens;
   logic [5:0] units;

   always_comb begin
      tens  = result_data / 6'd10;
      units = result_data % 6'd10;
   end

   assign high_digit_display = digit_segments(tens);
   assign low_digit_display  = digit_segments(units);

endmodule

// File: rtl/score_display_ctrl.sv
// rtl/score_display_ctrl.sv - game-phase display sequencer with score/high-score registers
module score_display_ctrl
   import simon_pkg::*;
#(
   parameter int TICK_DIV    = 12_500_000,
   parameter int BLINK_COUNT = 3,
   parameter int ALT_TICKS   = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       round_start,
   input  logic       score_valid,
   input  logic [5:0] score_in,
   input  logic       game_over,
   output logic [5:0] disp_value,
   output logic       disp_blank,
   output logic [6:0] high_digit_display,
   output logic [6:0] low_digit_display,
   output logic [5:0] high_score,
   output logic       new_record,
   output logic [1:0] mode
);

   localparam int TW          = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int FLASH_TICKS = 2 * BLINK_COUNT;
   localparam int PHASE_MAX   = (FLASH_TICKS > ALT_TICKS) ? FLASH_TICKS : ALT_TICKS;
   localparam int PW          = $clog2(PHASE_MAX + 1);

   disp_state_e   state, state_n;
   logic [TW-1:0] tick_cnt, tick_cnt_n;
   logic [PW-1:0] phase_cnt, phase_cnt_n;
   logic          alt_sel, alt_sel_n;
   logic [5:0]    score_reg, score_n;
   logic [5:0]    high_n;
   logic [5:0]    value_n;
   logic          blank_n;
   logic          record_n;
   logic [5:0]    eff_score;
   logic          tick;
   logic          entry;
   logic [6:0]    dec_high;
   logic [6:0]    dec_low;

   always_comb begin
      state_n     = state;
      score_n     = score_reg;
      high_n      = high_score;
      phase_cnt_n = phase_cnt;
      alt_sel_n   = alt_sel;
      blank_n     = disp_blank;
      record_n    = 1'b0;
      tick        = (tick_cnt == TW'(TICK_DIV - 1));
      eff_score   = score_valid ? score_in : score_reg;

      // A new game overrides whatever phase we are in, including a running blink.
      if (round_start) begin
         state_n     = S_PLAY;
         score_n     = 6'd0;
         blank_n     = 1'b0;
         phase_cnt_n = '0;
         alt_sel_n   = 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               blank_n = 1'b0;
            end
            S_PLAY: begin
               if (score_valid)
                  score_n = score_in;
               if (game_over) begin
                  phase_cnt_n = '0;
                  alt_sel_n   = 1'b0;
                  if (eff_score > high_score) begin
                     state_n  = S_FLASH;
                     high_n   = eff_score;
                     record_n = 1'b1;
                     blank_n  = 1'b1;
                  end else begin
                     state_n = S_OVER;
                     blank_n = 1'b0;
                  end
               end
            end
            S_FLASH: begin
               if (tick) begin
                  if (phase_cnt == PW'(FLASH_TICKS - 1)) begin
                     state_n     = S_OVER;
                     phase_cnt_n = '0;
                     alt_sel_n   = 1'b0;
                     blank_n     = 1'b0;
                  end else begin
                     phase_cnt_n = phase_cnt + PW'(1);
                     blank_n     = ~disp_blank;
                  end
               end
            end
            S_OVER: begin
               blank_n = 1'b0;
               if (tick) begin
                  if (phase_cnt == PW'(ALT_TICKS - 1)) begin
                     phase_cnt_n = '0;
                     alt_sel_n   = ~alt_sel;
                  end else begin
                     phase_cnt_n = phase_cnt + PW'(1);
                  end
               end
            end
            default: begin
               state_n = S_IDLE;
               blank_n = 1'b0;
            end
         endcase
      end

      // Restarting the divider on entry makes the first tick land TICK_DIV cycles later.
      entry = round_start || (state_n != state);
      if (entry || tick)
         tick_cnt_n = '0;
      else
         tick_cnt_n = tick_cnt + TW'(1);

      case (state_n)
         S_IDLE:  value_n = high_n;
         S_PLAY:  value_n = score_n;
         S_FLASH: value_n = score_n;
         S_OVER:  value_n = alt_sel_n ? high_n : score_n;
         default: value_n = 6'd0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= S_IDLE;
         tick_cnt   <= '0;
         phase_cnt  <= '0;
         alt_sel    <= 1'b0;
         score_reg  <= 6'd0;
         high_score <= 6'd0;
         disp_value <= 6'd0;
         disp_blank <= 1'b0;
         new_record <= 1'b0;
      end else begin
         state      <= state_n;
         tick_cnt   <= tick_cnt_n;
         phase_cnt  <= phase_cnt_n;
         alt_sel    <= alt_sel_n;
         score_reg  <= score_n;
         high_score <= high_n;
         disp_value <= value_n;
         disp_blank <= blank_n;
         new_record <= record_n;
      end
   end

   score_display_ctrl_seven_seg u_seven_seg (
      .result_data        (disp_value),
      .high_digit_display (dec_high),
      .low_digit_display  (dec_low)
   );

   assign high_digit_display = disp_blank ? SEG_BLANK : dec_high;
   assign low_digit_display  = disp_blank ? SEG_BLANK : dec_low;
   assign mode               = state;

endmodule

// File: tb/tb_score_display_ctrl.sv
// tb/tb_score_display_ctrl.sv - table-driven scoreboard bench for score_display_ctrl
module tb_score_display_ctrl;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       round_start = 1'b0;
   logic       score_valid = 1'b0;
   logic [5:0] score_in = 6'd0;
   logic       game_over = 1'b0;
   logic [5:0] disp_value;
   logic       disp_blank;
   logic [6:0] high_digit_display;
   logic [6:0] low_digit_display;
   logic [5:0] high_score;
   logic       new_record;
   logic [1:0] mode;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic       rst;
      logic       rs;
      logic       sv;
      logic [5:0] sin;
      logic       go;
      int         n;
      logic [1:0] e_mode;
      logic [5:0] e_val;
      logic       e_blank;
      logic [5:0] e_hs;
      logic       e_nr;
   } vec_t;

   typedef struct {
      int         row;
      logic [1:0] mode;
      logic [5:0] val;
      logic       blank;
      logic [5:0] hs;
      logic       nr;
      logic [6:0] hi;
      logic [6:0] lo;
   } exp_t;

   vec_t tbl[$];
   exp_t sb[$];
   logic [6:0] seg_tbl [10];

   score_display_ctrl #(
      .TICK_DIV    (4),
      .BLINK_COUNT (3),
      .ALT_TICKS   (2)
   ) dut (
      .clk                (clk),
      .reset              (reset),
      .round_start        (round_start),
      .score_valid        (score_valid),
      .score_in           (score_in),
      .game_over          (game_over),
      .disp_value         (disp_value),
      .disp_blank         (disp_blank),
      .high_digit_display (high_digit_display),
      .low_digit_display  (low_digit_display),
      .high_score         (high_score),
      .new_record         (new_record),
      .mode               (mode)
   );

   always #5 clk = ~clk;

   function automatic vec_t mk(input logic rst, input logic rs, input logic sv, input int sin,
                               input logic go, input int n, input int m, input int v,
                               input logic b, input int hs, input logic nr);
      vec_t r;
      r.rst = rst; r.rs = rs; r.sv = sv; r.sin = 6'(sin); r.go = go; r.n = n;
      r.e_mode = 2'(m); r.e_val = 6'(v); r.e_blank = b; r.e_hs = 6'(hs); r.e_nr = nr;
      return r;
   endfunction

   task automatic chk(input string name, input int row, input int got, input int want);
      checks++;
      if (got != want) begin
         errors++;
         $display("FAIL %s (row %0d): got %0d, expected %0d", name, row, got, want);
      end
   endtask

   task automatic drive_cycle(input logic rst, input logic rs, input logic sv,
                              input logic [5:0] sin, input logic go);
      @(negedge clk);
      reset = rst; round_start = rs; score_valid = sv; score_in = sin; game_over = go;
      @(posedge clk);
      #1;
   endtask

   task automatic check_head();
      exp_t e;
      if (sb.size() == 0) begin
         errors++;
         $display("FAIL scoreboard: queue empty when output sampled");
         return;
      end
      e = sb.pop_front();
      chk("mode",       e.row, int'(mode),               int'(e.mode));
      chk("disp_value", e.row, int'(disp_value),         int'(e.val));
      chk("disp_blank", e.row, int'(disp_blank),         int'(e.blank));
      chk("high_score", e.row, int'(high_score),         int'(e.hs));
      chk("new_record", e.row, int'(new_record),         int'(e.nr));
      chk("high_digit", e.row, int'(high_digit_display), int'(e.hi));
      chk("low_digit",  e.row, int'(low_digit_display),  int'(e.lo));
   endtask

   initial begin
      int cyc;
      int pulses;
      int toggles;
      logic prev_blank;

      seg_tbl = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                  7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

      //             rst rs sv sin go  n  mode val blk hs nr
      tbl.push_back(mk(1, 0, 0,  0, 0, 2, 0,  0, 0,  0, 0));  // reset held
      tbl.push_back(mk(0, 0, 0,  0, 0, 2, 0,  0, 0,  0, 0));
      tbl.push_back(mk(0, 0, 1,  5, 0, 1, 0,  0, 0,  0, 0));  // score_valid ignored in idle
      tbl.push_back(mk(0, 0, 0,  0, 1, 2, 0,  0, 0,  0, 0));  // game_over ignored in idle
      tbl.push_back(mk(0, 1, 0,  0, 0, 1, 1,  0, 0,  0, 0));
      tbl.push_back(mk(0, 0, 1, 27, 0, 3, 1, 27, 0,  0, 0));
      tbl.push_back(mk(0, 0, 0,  0, 1, 1, 2, 27, 1, 27, 1));  // new record
      tbl.push_back(mk(0, 0, 0,  0, 0, 3, 2, 27, 1, 27, 0));
      tbl.push_back(mk(0, 0, 1,  9, 0, 4, 2, 27, 0, 27, 0));  // blink off, sv ignored
      tbl.push_back(mk(0, 0, 0,  0, 1, 4, 2, 27, 1, 27, 0));  // go ignored
      tbl.push_back(mk(0, 0, 0,  0, 0, 4, 2, 27, 0, 27, 0));
      tbl.push_back(mk(0, 0, 0,  0, 0, 4, 2, 27, 1, 27, 0));
      tbl.push_back(mk(0, 0, 0,  0, 0, 4, 2, 27, 0, 27, 0));
      tbl.push_back(mk(0, 0, 0,  0, 0, 8, 3, 27, 0, 27, 0));  // over
      tbl.push_back(mk(0, 1, 0,  0, 0, 1, 1,  0, 0, 27, 0));
      tbl.push_back(mk(0, 0, 1, 12, 0, 2, 1, 12, 0, 27, 0));
      tbl.push_back(mk(0, 0, 0,  0, 1, 8, 3, 12, 0, 27, 0));  // no record, alternate
      tbl.push_back(mk(0, 0, 1, 50, 1, 8, 3, 27, 0, 27, 0));
      tbl.push_back(mk(0, 0, 0,  0, 0, 8, 3, 12, 0, 27, 0));
      tbl.push_back(mk(0, 0, 0,  0, 0, 4, 3, 27, 0, 27, 0));
      tbl.push_back(mk(0, 1, 0,  0, 0, 1, 1,  0, 0, 27, 0));
      tbl.push_back(mk(0, 0, 1, 35, 1, 1, 2, 35, 1, 35, 1));  // same-cycle sv+go
      tbl.push_back(mk(0, 0, 0,  0, 0, 2, 2, 35, 1, 35, 0));
      tbl.push_back(mk(0, 1, 0,  0, 0, 1, 1,  0, 0, 35, 0));  // round_start aborts blink
      tbl.push_back(mk(0, 0, 1, 40, 0, 1, 1, 40, 0, 35, 0));
      tbl.push_back(mk(0, 1, 0,  0, 1, 1, 1,  0, 0, 35, 0));  // round_start beats game_over
      tbl.push_back(mk(0, 0, 1, 35, 0, 1, 1, 35, 0, 35, 0));
      tbl.push_back(mk(0, 0, 0,  0, 1, 2, 3, 35, 0, 35, 0));  // equal is not a record
      tbl.push_back(mk(0, 1, 0,  0, 0, 1, 1,  0, 0, 35, 0));
      tbl.push_back(mk(0, 0, 1, 35, 1, 1, 3, 35, 0, 35, 0));  // equal via same-cycle sv
      tbl.push_back(mk(0, 1, 0,  0, 0, 1, 1,  0, 0, 35, 0));
      tbl.push_back(mk(0, 0, 1, 63, 1, 1, 2, 63, 1, 63, 1));  // max score record
      tbl.push_back(mk(0, 0, 0,  0, 0, 3, 2, 63, 1, 63, 0));
      tbl.push_back(mk(0, 0, 0,  0, 0, 2, 2, 63, 0, 63, 0));
      tbl.push_back(mk(1, 0, 0,  0, 0, 1, 0,  0, 0,  0, 0));  // reset mid-blink
      tbl.push_back(mk(0, 0, 0,  0, 0, 2, 0,  0, 0,  0, 0));

      for (int r = 0; r < tbl.size(); r++) begin
         for (int c = 0; c < tbl[r].n; c++) begin
            exp_t e;
            e.row   = r;
            e.mode  = tbl[r].e_mode;
            e.val   = tbl[r].e_val;
            e.blank = tbl[r].e_blank;
            e.hs    = tbl[r].e_hs;
            e.nr    = (c == 0) ? tbl[r].e_nr : 1'b0;
            e.hi    = tbl[r].e_blank ? 7'b1111111 : seg_tbl[int'(tbl[r].e_val) / 10];
            e.lo    = tbl[r].e_blank ? 7'b1111111 : seg_tbl[int'(tbl[r].e_val) % 10];
            sb.push_back(e);
            if (c == 0)
               drive_cycle(tbl[r].rst, tbl[r].rs, tbl[r].sv, tbl[r].sin, tbl[r].go);
            else
               drive_cycle(tbl[r].rst, 1'b0, 1'b0, 6'd0, 1'b0);
            check_head();
         end
      end

      // Full blink sequence timed end to end with a bounded wait.
      drive_cycle(1'b0, 1'b1, 1'b0, 6'd0, 1'b0);
      drive_cycle(1'b0, 1'b0, 1'b1, 6'd10, 1'b0);
      drive_cycle(1'b0, 1'b0, 1'b0, 6'd0, 1'b1);
      pulses     = int'(new_record);
      toggles    = 0;
      prev_blank = disp_blank;
      cyc        = 0;
      while (mode != 2'd3 && cyc < 40) begin
         drive_cycle(1'b0, 1'b0, 1'b0, 6'd0, 1'b0);
         cyc++;
         pulses += int'(new_record);
         if (disp_blank != prev_blank)
            toggles++;
         prev_blank = disp_blank;
      end
      chk("flash_to_over_mode",   100, int'(mode), 3);
      chk("flash_length_cycles",  100, cyc, 24);
      chk("new_record_pulses",    100, pulses, 1);
      chk("blank_toggles",        100, toggles, 5);
      chk("over_value_after_rec", 100, int'(disp_value), 10);
      chk("over_high_after_rec",  100, int'(high_score), 10);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
